// File: rtl/div_arbiter_seq.sv
// Two-requester arbitrated restoring divider.
// Requesters share one sequential unsigned divider. Grants alternate when both
// requesters are valid. A result is held until the consumer takes it.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a request; the granted requester sees ready
// CALC  | restoring division, one quotient bit per edge, MSB first
// DONE  | result presented on rsp_*; held until rsp_ready is sampled
module div_arbiter_seq #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_dividend,
  input  logic [W-1:0] req0_divisor,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_dividend,
  input  logic [W-1:0] req1_divisor,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_quotient,
  output logic [W-1:0] rsp_remainder,
  output logic         rsp_error,
  output logic         busy
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic            last_grant;
  logic            grant_id;
  logic            accept;
  logic [W-1:0]    acc_dividend;
  logic [W-1:0]    acc_divisor;

  // Dividend is consumed MSB first by shifting it out of the top.
  logic [W-1:0]    dvd_sh;
  logic [W-1:0]    dvs;
  logic [W:0]      rem;
  logic [W-1:0]    quo;
  logic [CW-1:0]   cnt;

  logic [W:0]      rem_shift;
  logic [W:0]      rem_next;
  logic            q_bit;

  // Grant selection: single valid wins outright, contention goes to the
  // requester that was not granted last time.
  always_comb begin
    grant_id = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant;
    end else begin
      grant_id = req1_valid;
    end
  end

  assign req0_ready   = rst_n && (state == IDLE) && req0_valid && !grant_id;
  assign req1_ready   = rst_n && (state == IDLE) && req1_valid &&  grant_id;
  assign accept       = req0_ready || req1_ready;
  assign acc_dividend = grant_id ? req1_dividend : req0_dividend;
  assign acc_divisor  = grant_id ? req1_divisor  : req0_divisor;
  assign busy         = (state != IDLE);

  // One restoring-division step: shift in the next dividend bit, then
  // subtract the divisor if it fits. The extra remainder bit keeps the
  // shifted value from overflowing when the divisor is near 2^W-1.
  always_comb begin
    rem_shift = (rem << 1) | {{W{1'b0}}, dvd_sh[W-1]};
    q_bit     = (rem_shift >= {1'b0, dvs});
    rem_next  = q_bit ? (rem_shift - {1'b0, dvs}) : rem_shift;
  end

  // Sequencer, datapath and registered response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      dvd_sh        <= '0;
      dvs           <= '0;
      rem           <= '0;
      quo           <= '0;
      cnt           <= '0;
      rsp_valid     <= 1'b0;
      rsp_id        <= 1'b0;
      rsp_quotient  <= '0;
      rsp_remainder <= '0;
      rsp_error     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            last_grant <= grant_id;
            rsp_id     <= grant_id;
            dvd_sh     <= acc_dividend;
            dvs        <= acc_divisor;
            rem        <= '0;
            quo        <= '0;
            cnt        <= CW'(W - 1);
            if (acc_divisor == '0) begin
              state         <= DONE;
              rsp_valid     <= 1'b1;
              rsp_quotient  <= '0;
              rsp_remainder <= '0;
              rsp_error     <= 1'b1;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem    <= rem_next;
          quo    <= {quo[W-2:0], q_bit};
          dvd_sh <= dvd_sh << 1;
          cnt    <= cnt - 1'b1;
          if (cnt == '0) begin
            state         <= DONE;
            rsp_valid     <= 1'b1;
            rsp_quotient  <= {quo[W-2:0], q_bit};
            rsp_remainder <= rem_next[W-1:0];
            rsp_error     <= 1'b0;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_arbiter_seq.sv
// Bench for div_arbiter_seq: directed scenarios plus randomized traffic,
// checked against a plain arithmetic reference with a round-robin pointer.
module tb_div_arbiter_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0;
  logic         req0_ready;
  logic [W-1:0] req0_dividend = '0;
  logic [W-1:0] req0_divisor = '0;
  logic         req1_valid = 1'b0;
  logic         req1_ready;
  logic [W-1:0] req1_dividend = '0;
  logic [W-1:0] req1_divisor = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic         rsp_id;
  logic [W-1:0] rsp_quotient;
  logic [W-1:0] rsp_remainder;
  logic         rsp_error;
  logic         busy;

  div_arbiter_seq #(.W(W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req0_valid    (req0_valid),
    .req0_ready    (req0_ready),
    .req0_dividend (req0_dividend),
    .req0_divisor  (req0_divisor),
    .req1_valid    (req1_valid),
    .req1_ready    (req1_ready),
    .req1_dividend (req1_dividend),
    .req1_divisor  (req1_divisor),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_id        (rsp_id),
    .rsp_quotient  (rsp_quotient),
    .rsp_remainder (rsp_remainder),
    .rsp_error     (rsp_error),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  // Reference state: pending requests per requester and the grant pointer.
  bit       pend_v [2];
  int       pend_a [2];
  int       pend_b [2];
  int       model_last = 1;
  int       last_gid = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_reqs();
    req0_valid    = pend_v[0];
    req0_dividend = W'(pend_a[0]);
    req0_divisor  = W'(pend_b[0]);
    req1_valid    = pend_v[1];
    req1_dividend = W'(pend_a[1]);
    req1_divisor  = W'(pend_b[1]);
  endtask

  function automatic int pick_val();
    case ($urandom_range(0, 5))
      0:       return 0;
      1:       return 1;
      2:       return (1 << W) - 1;
      default: return int'($urandom_range(0, (1 << W) - 1));
    endcase
  endfunction

  // Runs one arbitrated operation from the pending set to response handoff.
  task automatic run_op(input int hold, input bit tied);
    int g, lat, a, b, eq, er, ee, el;
    logic [31:0] exp_rsp;
    rsp_ready = tied;
    drive_reqs();
    #1;
    if (pend_v[0] && pend_v[1]) g = (model_last == 0) ? 1 : 0;
    else g = pend_v[1] ? 1 : 0;
    chk("grant_ready", {busy, req0_ready, req1_ready}, {1'b0, g == 0, g == 1});
    a  = pend_a[g];
    b  = pend_b[g];
    ee = (b == 0) ? 1 : 0;
    eq = (b == 0) ? 0 : a / b;
    er = (b == 0) ? 0 : a % b;
    el = (b == 0) ? 1 : W + 1;
    exp_rsp = {13'd0, 1'b1, g[0], W'(eq), W'(er), ee[0]};
    tick();
    model_last = g;
    last_gid   = g;
    pend_v[g]  = 1'b0;
    pend_a[g]  = pick_val();
    pend_b[g]  = pick_val();
    drive_reqs();
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      chk("calc_busy", {busy, req0_ready, req1_ready}, 3'b100);
      if (!tied) rsp_ready = $urandom_range(0, 1);
      tick();
      lat++;
    end
    chk("latency", lat, el);
    chk("rsp", {rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_error}, exp_rsp);
    chk("done_busy", {busy, req0_ready, req1_ready}, 3'b100);
    for (int i = 0; i < hold; i++) begin
      rsp_ready = 1'b0;
      tick();
      chk("hold_rsp", {rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_error}, exp_rsp);
      chk("hold_busy", {busy, req0_ready, req1_ready}, 3'b100);
    end
    rsp_ready = 1'b1;
    tick();
    chk("handoff", {rsp_valid, busy}, 2'b00);
    rsp_ready = tied;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pend_v[0] = 1'b0;
    pend_v[1] = 1'b0;
    drive_reqs();
    model_last = 1;
    #1;
    chk("reset_outs", {busy, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_error,
                       req0_ready, req1_ready}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    bit seen;
    int hold;
    pend_v[0] = 0; pend_v[1] = 0;
    pend_a[0] = 0; pend_a[1] = 0;
    pend_b[0] = 0; pend_b[1] = 0;

    // Ready must stay low while reset is held even with requests pending.
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #2;
    chk("reset_ready", {req0_ready, req1_ready, busy, rsp_valid}, 4'b0000);
    do_reset();

    pend_v[0] = 1; pend_a[0] = 100; pend_b[0] = 7;
    run_op(0, 1'b0);
    chk("id_100_7", last_gid, 0);

    pend_v[1] = 1; pend_a[1] = 55; pend_b[1] = 0;
    run_op(0, 1'b0);

    // Contention straight after reset with the consumer always ready.
    do_reset();
    pend_v[0] = 1; pend_a[0] = 255; pend_b[0] = 1;
    pend_v[1] = 1; pend_a[1] = 255; pend_b[1] = 255;
    run_op(0, 1'b1);
    chk("first_grant", last_gid, 0);
    run_op(0, 1'b1);
    chk("second_grant", last_gid, 1);
    pend_v[0] = 1; pend_a[0] = 40; pend_b[0] = 6;
    pend_v[1] = 1; pend_a[1] = 90; pend_b[1] = 9;
    run_op(0, 1'b1);
    chk("third_grant", last_gid, 0);
    run_op(0, 1'b1);

    pend_v[0] = 1; pend_a[0] = 7; pend_b[0] = 200;
    run_op(5, 1'b0);

    // Reset lands on the 4th CALC edge of 200/3.
    pend_v[0] = 1; pend_a[0] = 200; pend_b[0] = 3;
    drive_reqs();
    #1;
    chk("rst_case_ready", req0_ready, 1'b1);
    tick();
    pend_v[0] = 0;
    drive_reqs();
    repeat (3) tick();
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_reset", {busy, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_error,
                        req0_ready, req1_ready}, 32'd0);
    model_last = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rsp_valid || busy) seen = 1'b1;
    end
    chk("no_ghost_rsp", seen, 1'b0);
    pend_v[0] = 1; pend_a[0] = 200; pend_b[0] = 3;
    run_op(0, 1'b0);

    pend_v[1] = 1; pend_a[1] = 0; pend_b[1] = 5;
    run_op(0, 1'b0);

    // Randomized traffic; a losing requester keeps its request pending.
    for (int n = 0; n < 60; n++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend_v[r] && $urandom_range(0, 2) != 0) begin
          pend_v[r] = 1;
          pend_a[r] = pick_val();
          pend_b[r] = pick_val();
        end
      end
      if (!pend_v[0] && !pend_v[1]) begin
        pend_v[0] = 1;
        pend_a[0] = pick_val();
        pend_b[0] = pick_val();
      end
      hold = $urandom_range(0, 3);
      run_op(hold, $urandom_range(0, 3) == 0);
    end
    while (pend_v[0] || pend_v[1]) run_op(0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
